i2c_reg_writer: RTL and testbench
=================================

// Module: i2c_reg_writer
// PURPOSE
//   I2C master, write-only. Performs single-register write transactions of the form
//   START / {SLV_ADDR,W} / ACK / reg_addr / ACK / wdata / ACK / STOP.
//   Host-side driver for the display slave: loads its register bank (slv_reg0..4:
//   coordinates, speed, trigger) from the video-processing datapath.
//   SCL is push-pull, since this is the single master and clock stretching is not supported.
//   SDA is open-drain through sda_oe / sda_in.
// PARAMETERS
//   CLK_FREQ  100_000_000  system clock frequency, Hz
//   I2C_FREQ  100_000      SCL frequency, Hz
//   SLV_ADDR  7'h2A        7-bit target slave address
//   CLK_DIV   CLK_FREQ/(4*I2C_FREQ) (=250)  clocks per SCL quarter-period (localparam)
// PORTS
//   clk       in   1  system clock
//   reset     in   1  synchronous, active-high reset
//   start     in   1  request a write; sampled only while busy=0
//   reg_addr  in   8  target register index; latched on an accepted start
//   wdata     in   8  data byte; latched on an accepted start
//   busy      out  1  transaction in progress
//   done      out  1  one-cycle pulse when STOP completes
//   ack_err   out  1  a NACK was seen in the last transaction; held until next accepted start
//   scl       out  1  I2C clock
//   sda_oe    out  1  1 = pull SDA low, 0 = release (external pull-up)
//   sda_in    in   1  SDA line level as seen at the pad
// BEHAVIOUR
//   Interface: one clock (clk). Reset is synchronous, active-high (reset).
//   Reset values: scl=1, sda_oe=0, busy=0, done=0, ack_err=0, state=IDLE, tick counter=0.
//     Reset mid-transaction aborts immediately. No STOP is generated.
//   Tick: a one-cycle pulse every CLK_DIV clocks, counting only while busy. Each bit period
//     is four quarters Q0..Q3, each quarter CLK_DIV clocks long.
//   Data-bit quarters: Q0 scl=0, SDA updated | Q1 scl=1 | Q2 scl=1 | Q3 scl=0.
//     SDA changes only in Q0, except in START and STOP.
//   Accept: start=1 && busy=0 -> latch reg_addr/wdata, clear ack_err, busy=1 on the next cycle.
//     start while busy=1 is ignored.
//   FSM:
//     IDLE  scl=1, sda_oe=0
//     START Q0-Q1 SDA released | Q2 SDA low | Q3 scl=0
//     ADDR  8 bits, MSB first: {SLV_ADDR,1'b0}
//     ACK1  SDA released; sample sda_in on the last clk of Q1
//     REG   8 bits
//     ACK2
//     DATA  8 bits
//     ACK3
//     STOP  Q0 scl=0, SDA low | Q1 scl=1, SDA low | Q2-Q3 scl=1, SDA released
//     IDLE
//   Sampled sda_in=1 in any ACK state: set ack_err=1 and go directly to STOP.
//     Remaining bytes are skipped.
//   STOP completion: done=1 for one cycle; busy=0 in that same cycle.
//     A start in that cycle is not accepted. It is accepted from the next cycle on.
//   Full transaction = 29 bit periods = 116*CLK_DIV clocks (29000 at defaults).
//   Bit counter is 3 bits and wraps 7->0 at byte end. The shift register is 8 bits, MSB out.
// STRUCTURE
//   Package i2c_pkg holds:
//     state enum: IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP
//     quarter-phase constants Q0..Q3
//     I2C_WR=1'b0, I2C_RD=1'b1
//   Sub-module i2c_tick_gen: parameter CLK_DIV; ports clk, reset, en, tick.
//     Counter clears when en=0.
//   Top level holds the FSM, quarter counter, bit counter and shift register.
// TESTING (bench uses an open-drain SDA model and a behavioural slave that ACKs by default)
//   1. reg_addr=8'h02, wdata=8'h5A, start -> SDA bytes 8'h54, 8'h02, 8'h5A, each ACKed;
//      done pulses once; ack_err=0; busy high for exactly 116*CLK_DIV clocks.
//   2. Slave NACKs the address byte -> ack_err=1, STOP follows ACK1 directly;
//      REG and DATA are never driven; done pulses.
//   3. Second start pulse mid-DATA with different reg_addr/wdata -> ignored;
//      the wire carries only the first transaction.
//   4. reset asserted during REG -> next cycle scl=1, sda_oe=0, busy=0, done=0;
//      a subsequent start completes normally.
//   5. Protocol checker across tests 1-4: SDA changes while scl=1 only at START (fall)
//      and STOP (rise); SCL period = 4*CLK_DIV clocks.
//   6. start held high continuously -> back-to-back transactions, each separated by
//      exactly 1 idle cycle after done.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C register master.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    function automatic logic is_ack(state_t s);
        return (s == ACK1) || (s == ACK2) || (s == ACK3);
    endfunction

    function automatic logic is_byte(state_t s);
        return (s == ADDR) || (s == REG) || (s == DATA);
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period strobe: one-cycle pulse every CLK_DIV clocks while en is high.
module i2c_tick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Held at zero while idle so every transaction starts on a full quarter.
    always_ff @(posedge clk) begin
        if (reset || !en)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_reg_writer.sv
// Single-master, write-only I2C: START / addr+W / reg / data / STOP, each byte ACK-checked.
module i2c_reg_writer
    import i2c_pkg::*;
#(
    parameter int         CLK_FREQ = 100_000_000,
    parameter int         I2C_FREQ = 100_000,
    parameter logic [6:0] SLV_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int CLK_DIV = CLK_FREQ / (4 * I2C_FREQ);

    state_t     state, state_nxt;
    logic [1:0] qtr;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, reg_q, data_q;
    logic       tick, accept, bit_end, byte_end, ack_smp;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .tick  (tick)
    );

    assign busy     = (state != IDLE);
    // The done cycle is excluded so back-to-back requests get one idle cycle.
    assign accept   = start && !busy && !done;
    assign bit_end  = tick && (qtr == Q3);
    assign byte_end = bit_end && (bit_cnt == 3'd7);
    assign ack_smp  = tick && (qtr == Q1) && is_ack(state);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept)   state_nxt = START;
            START: if (bit_end)  state_nxt = ADDR;
            ADDR:  if (byte_end) state_nxt = ACK1;
            ACK1:  if (bit_end)  state_nxt = ack_err ? STOP : REG;
            REG:   if (byte_end) state_nxt = ACK2;
            ACK2:  if (bit_end)  state_nxt = ack_err ? STOP : DATA;
            DATA:  if (byte_end) state_nxt = ACK3;
            ACK3:  if (bit_end)  state_nxt = STOP;
            STOP:  if (bit_end)  state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        unique case (state)
            IDLE: ;
            START: begin
                scl    = (qtr != Q3);
                sda_oe = (qtr == Q2) || (qtr == Q3);
            end
            ADDR, REG, DATA: begin
                scl    = (qtr == Q1) || (qtr == Q2);
                sda_oe = !shreg[7];
            end
            ACK1, ACK2, ACK3: begin
                scl    = (qtr == Q1) || (qtr == Q2);
            end
            STOP: begin
                scl    = (qtr != Q0);
                sda_oe = (qtr == Q0) || (qtr == Q1);
            end
            default: ;
        endcase
    end

    // Shift happens at the end of Q3, so SDA moves at the start of the next Q0.
    always_ff @(posedge clk) begin
        if (reset) begin
            qtr     <= Q0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            reg_q   <= 8'd0;
            data_q  <= 8'd0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            done <= (state == STOP) && bit_end;
            if (accept) begin
                reg_q   <= reg_addr;
                data_q  <= wdata;
                shreg   <= {SLV_ADDR, I2C_WR};
                ack_err <= 1'b0;
                qtr     <= Q0;
                bit_cnt <= 3'd0;
            end else begin
                if (tick)
                    qtr <= qtr + 2'd1;
                if (ack_smp && sda_in)
                    ack_err <= 1'b1;
                if (bit_end && is_byte(state)) begin
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (bit_end && state == ACK1)
                    shreg <= reg_q;
                if (bit_end && state == ACK2)
                    shreg <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Directed bench for i2c_reg_writer with an open-drain bus, an ACKing slave model and a protocol monitor.
module tb_i2c_reg_writer;

    localparam int CDIV     = 10;          // 4 MHz / (4 * 100 kHz)
    localparam int TXN_CYC  = 1160;        // 116 quarters * 10
    localparam int NACK_CYC = 440;         // START + 8 addr + ACK1 + STOP = 11 bits * 40

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, ack_err, scl, sda_oe;
    logic       sda_line;

    int checks = 0;
    int failures = 0;

    // Slave / monitor state
    logic       slv_pull = 1'b0;
    logic       scl_d = 1'b1, sda_d = 1'b1;
    logic       bus_act = 1'b0;
    logic [7:0] slv_sh = 8'h00;
    int         bitn = 0, byte_idx = 0, nack_byte = -1;
    int         n_start = 0, n_stop = 0, done_cnt = 0;
    int         cyc = 0, last_rise = -1;
    logic [7:0] rx_q[$];

    assign sda_line = !(sda_oe || slv_pull);

    always #5 clk = ~clk;

    i2c_reg_writer #(
        .CLK_FREQ (4_000_000),
        .I2C_FREQ (100_000),
        .SLV_ADDR (7'h2A)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl      (scl),
        .sda_oe   (sda_oe),
        .sda_in   (sda_line)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural slave plus START/STOP legality and SCL period monitor.
    always @(posedge clk) begin
        if (reset) begin
            bus_act  <= 1'b0;
            slv_pull <= 1'b0;
            bitn     <= 0;
        end else if (scl_d && scl && sda_d && !sda_line) begin
            check("start_only_when_idle", {31'd0, bus_act}, 32'd0);
            bus_act   <= 1'b1;
            bitn      <= 0;
            byte_idx  <= 0;
            last_rise <= -1;
            n_start++;
        end else if (scl_d && scl && !sda_d && sda_line) begin
            check("stop_only_when_active", {31'd0, bus_act}, 32'd1);
            bus_act  <= 1'b0;
            slv_pull <= 1'b0;
            n_stop++;
        end else if (bus_act) begin
            if (!scl_d && scl) begin
                if (last_rise >= 0)
                    check("scl_period", cyc - last_rise, 4 * CDIV);
                last_rise <= cyc;
                if (bitn < 8)
                    slv_sh <= {slv_sh[6:0], sda_line};
                bitn <= bitn + 1;
            end else if (scl_d && !scl) begin
                if (bitn == 8) begin
                    rx_q.push_back(slv_sh);
                    slv_pull <= (byte_idx != nack_byte);
                end else if (bitn == 9) begin
                    slv_pull <= 1'b0;
                    bitn     <= 0;
                    byte_idx <= byte_idx + 1;
                end
            end
        end
        scl_d <= scl;
        sda_d <= sda_line;
        cyc++;
    end

    always @(negedge clk)
        if (done) done_cnt++;

    // Issues one request; optionally pulses a second start with other operands at busy cycle inj_at.
    task automatic run_txn(input logic [7:0] ra, input logic [7:0] wd, input int inj_at,
                           output int bcyc, output logic got_done);
        @(posedge clk); #1;
        start = 1'b1; reg_addr = ra; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0; reg_addr = ~ra; wdata = ~wd;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("ack_err_cleared", {31'd0, ack_err}, 32'd0);
        bcyc = 0;
        while (busy && bcyc < 5000) begin
            start = (bcyc == inj_at);
            if (start) begin reg_addr = 8'hEE; wdata = 8'h77; end
            @(posedge clk); #1;
            bcyc++;
        end
        start = 1'b0;
        got_done = done;
    endtask

    initial begin
        int         bc, d0, s0, p0;
        logic       gd;
        logic [7:0] exp6 [6];

        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", {31'd0, scl}, 32'd1);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ack_err", {31'd0, ack_err}, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // 1: normal write 02 <= 5A
        rx_q.delete(); d0 = done_cnt; s0 = n_start; p0 = n_stop;
        run_txn(8'h02, 8'h5A, -1, bc, gd);
        check("t1_busy_cycles", bc, TXN_CYC);
        check("t1_done", {31'd0, gd}, 32'd1);
        check("t1_ack_err", {31'd0, ack_err}, 32'd0);
        check("t1_nbytes", rx_q.size(), 3);
        check("t1_byte0", {24'd0, rx_q[0]}, 32'h54);
        check("t1_byte1", {24'd0, rx_q[1]}, 32'h02);
        check("t1_byte2", {24'd0, rx_q[2]}, 32'h5A);
        check("t1_starts", n_start - s0, 1);
        check("t1_stops", n_stop - p0, 1);
        @(posedge clk); #1;
        check("t1_done_one_cycle", {31'd0, done}, 32'd0);
        check("t1_done_count", done_cnt - d0, 1);

        // 2: slave NACKs the address byte
        repeat (3) @(posedge clk);
        rx_q.delete(); d0 = done_cnt; p0 = n_stop; nack_byte = 0;
        run_txn(8'h03, 8'hA5, -1, bc, gd);
        nack_byte = -1;
        check("t2_busy_cycles", bc, NACK_CYC);
        check("t2_done", {31'd0, gd}, 32'd1);
        check("t2_ack_err", {31'd0, ack_err}, 32'd1);
        check("t2_nbytes", rx_q.size(), 1);
        check("t2_byte0", {24'd0, rx_q[0]}, 32'h54);
        check("t2_stops", n_stop - p0, 1);
        repeat (5) @(posedge clk);
        #1;
        check("t2_ack_err_held", {31'd0, ack_err}, 32'd1);
        check("t2_done_count", done_cnt - d0, 1);

        // 3: second start during DATA (bit 19) is ignored
        rx_q.delete();
        run_txn(8'h11, 8'hC3, 19 * 4 * CDIV + 15, bc, gd);
        check("t3_busy_cycles", bc, TXN_CYC);
        check("t3_done", {31'd0, gd}, 32'd1);
        check("t3_nbytes", rx_q.size(), 3);
        check("t3_byte1", {24'd0, rx_q[1]}, 32'h11);
        check("t3_byte2", {24'd0, rx_q[2]}, 32'hC3);
        repeat (2) @(posedge clk);
        #1;
        check("t3_no_restart", {31'd0, busy}, 32'd0);

        // 4: reset during first REG bit (Q0), then a clean transaction
        rx_q.delete(); p0 = n_stop; d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; reg_addr = 8'h33; wdata = 8'h44;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (402) @(posedge clk);
        #1;
        check("t4_scl_low_before_rst", {31'd0, scl}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t4_rst_scl", {31'd0, scl}, 32'd1);
        check("t4_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        check("t4_nbytes", rx_q.size(), 1);
        check("t4_no_stop", n_stop - p0, 0);
        check("t4_no_done", done_cnt - d0, 0);
        repeat (3) @(posedge clk);
        rx_q.delete();
        run_txn(8'h04, 8'h9F, -1, bc, gd);
        check("t4b_busy_cycles", bc, TXN_CYC);
        check("t4b_done", {31'd0, gd}, 32'd1);
        check("t4b_nbytes", rx_q.size(), 3);
        check("t4b_byte1", {24'd0, rx_q[1]}, 32'h04);
        check("t4b_byte2", {24'd0, rx_q[2]}, 32'h9F);

        // 6: start held high -> back-to-back with one idle cycle after done
        repeat (3) @(posedge clk);
        rx_q.delete();
        @(posedge clk); #1;
        start = 1'b1; reg_addr = 8'h01; wdata = 8'h02;
        bc = 0;
        do begin @(posedge clk); #1; bc++; end while (!done && bc < 3000);
        check("t6_done1", {31'd0, done}, 32'd1);
        check("t6_busy_low_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("t6_idle_gap", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("t6_reaccept", {31'd0, busy}, 32'd1);
        bc = 0;
        do begin @(posedge clk); #1; bc++; end while (!done && bc < 3000);
        check("t6_done2", {31'd0, done}, 32'd1);
        check("t6_b2b_cycles", bc, TXN_CYC);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_stays_idle", {31'd0, busy}, 32'd0);
        exp6 = '{8'h54, 8'h01, 8'h02, 8'h54, 8'h01, 8'h02};
        check("t6_nbytes", rx_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t6_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp6[i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
